jb_iq_power_meter: RTL and testbench

//  Sits directly downstream of jb_iq_gain_mult. Passes the IQ stream through with one register stage.
//  In parallel, measures windowed mean power (I^2+Q^2), peak per-sample power and full-scale (clip)

---
 rtl/jb_iq_meas_pkg.sv | 20 ++
 rtl/jb_axi4_stream_if.sv | 17 +
 rtl/jb_iq_pwr_calc.sv | 83 ++++++++
 rtl/jb_iq_power_meter.sv | 187 ++++++++++++++++++
 tb/tb_jb_iq_power_meter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jb_iq_meas_pkg.sv
// Shared types and width helpers for the IQ power meter.
package jb_iq_meas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ACCUM
    } meas_state_t;

    function automatic int unsigned pwr_w(input int unsigned precision);
        return 2 * precision + 1;
    endfunction

    // Accumulator holds a full window of max-power samples without overflow.
    function automatic int unsigned acc_w(input int unsigned precision,
                                          input int unsigned log2_win);
        return pwr_w(precision) + log2_win;
    endfunction

endpackage

// File: rtl/jb_axi4_stream_if.sv
// Minimal AXI4-Stream bundle used between DFE blocks.
interface jb_axi4_stream_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned USER_W = 2
);
    logic [DATA_W-1:0]   tdata;
    logic                tvalid;
    logic                tready;
    logic                tlast;
    logic [USER_W-1:0]   tuser;
    logic [DATA_W/8-1:0] tkeep;

    modport master (output tdata, output tvalid, output tlast, output tuser, output tkeep,
                    input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, input tkeep,
                    output tready);
endinterface

// File: rtl/jb_iq_pwr_calc.sv
// Three-stage I^2+Q^2 pipeline with valid/last/clip side-band delayed alongside.
module jb_iq_pwr_calc
    import jb_iq_meas_pkg::*;
#(
    parameter int unsigned PRECISION = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic [PRECISION-1:0]          i_i,
    input  logic [PRECISION-1:0]          q_i,
    input  logic                          valid_i,
    input  logic                          last_i,
    output logic [pwr_w(PRECISION)-1:0]   p_o,
    output logic                          valid_o,
    output logic                          last_o,
    output logic                          clip_o
);

    localparam int unsigned SqW = 2 * PRECISION;
    localparam int unsigned PW  = pwr_w(PRECISION);
    localparam logic [PRECISION-1:0] MaxV = {1'b0, {(PRECISION-1){1'b1}}};
    localparam logic [PRECISION-1:0] MinV = {1'b1, {(PRECISION-1){1'b0}}};

    logic signed [PRECISION-1:0] i_q, q_q;
    logic                        v1_q, l1_q, c1_q;
    logic signed [SqW-1:0]       ii_q, qq_q;
    logic                        v2_q, l2_q, c2_q;
    logic [PW-1:0]               p_q;
    logic                        v3_q, l3_q, c3_q;

    logic                        c1_d;
    logic signed [SqW-1:0]       ii_d, qq_d;
    logic [PW-1:0]               p_d;

    always_comb begin
        c1_d = (i_i == MaxV) || (i_i == MinV) || (q_i == MaxV) || (q_i == MinV);
        ii_d = SqW'(i_q) * SqW'(i_q);
        qq_d = SqW'(q_q) * SqW'(q_q);
        // Squares are non-negative, so zero extension is exact.
        p_d  = {1'b0, ii_q} + {1'b0, qq_q};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            i_q  <= '0;
            q_q  <= '0;
            v1_q <= 1'b0;
            l1_q <= 1'b0;
            c1_q <= 1'b0;
            ii_q <= '0;
            qq_q <= '0;
            v2_q <= 1'b0;
            l2_q <= 1'b0;
            c2_q <= 1'b0;
            p_q  <= '0;
            v3_q <= 1'b0;
            l3_q <= 1'b0;
            c3_q <= 1'b0;
        end else if (en_i) begin
            i_q  <= i_i;
            q_q  <= q_i;
            v1_q <= valid_i;
            l1_q <= last_i;
            c1_q <= c1_d;
            ii_q <= ii_d;
            qq_q <= qq_d;
            v2_q <= v1_q;
            l2_q <= l1_q;
            c2_q <= c1_q;
            p_q  <= p_d;
            v3_q <= v2_q;
            l3_q <= l2_q;
            c3_q <= c2_q;
        end
    end

    assign p_o     = p_q;
    assign valid_o = v3_q;
    assign last_o  = l3_q;
    assign clip_o  = c3_q;

endmodule

// File: rtl/jb_iq_power_meter.sv
// IQ pass-through with windowed mean power, peak power and clip-count measurement.
module jb_iq_power_meter
    import jb_iq_meas_pkg::*;
#(
    parameter int unsigned PRECISION  = 16,
    parameter int unsigned USR_ID_BW  = 2,
    parameter int unsigned LOG2_WIN   = 10,
    parameter int unsigned SYNC_TLAST = 0
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        clk_en,
    input  logic                        meas_en,
    jb_axi4_stream_if.slave             IFP_dfe_in,
    jb_axi4_stream_if.master            IFP_dfe_out,
    output logic                        meas_valid,
    output logic [pwr_w(PRECISION)-1:0] pwr_avg,
    output logic [pwr_w(PRECISION)-1:0] pwr_peak,
    output logic [LOG2_WIN:0]           clip_cnt
);

    localparam int unsigned PW = pwr_w(PRECISION);
    localparam int unsigned AW = acc_w(PRECISION, LOG2_WIN);
    localparam int unsigned DW = 2 * PRECISION;

    logic [DW-1:0]        tdata_q;
    logic                 tvalid_q, tlast_q;
    logic [USR_ID_BW-1:0] tuser_q;

    logic [PW-1:0]        e3_p;
    logic                 e3_valid, e3_last, e3_clip;

    meas_state_t          state_q, state_d;
    logic                 accum_en;

    logic [AW-1:0]        acc_q, acc_d, acc_base;
    logic [PW-1:0]        peak_q, peak_d, peak_base;
    logic [LOG2_WIN:0]    clip_q, clip_d, clip_base;
    logic [LOG2_WIN-1:0]  cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 mv_q, mv_d;
    logic [PW-1:0]        avg_q, avg_d, rpeak_q, rpeak_d;
    logic [LOG2_WIN:0]    rclip_q, rclip_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= '0;
        end else if (clk_en) begin
            tdata_q  <= IFP_dfe_in.tdata[DW-1:0];
            tvalid_q <= IFP_dfe_in.tvalid;
            tlast_q  <= IFP_dfe_in.tlast;
            tuser_q  <= IFP_dfe_in.tuser;
        end
    end

    assign IFP_dfe_in.tready  = 1'b1;
    assign IFP_dfe_out.tdata  = tdata_q;
    assign IFP_dfe_out.tvalid = tvalid_q;
    assign IFP_dfe_out.tlast  = tlast_q;
    assign IFP_dfe_out.tuser  = tuser_q;
    assign IFP_dfe_out.tkeep  = '1;

    jb_iq_pwr_calc #(
        .PRECISION (PRECISION)
    ) u_pwr_calc (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .en_i    (clk_en),
        .i_i     (IFP_dfe_in.tdata[PRECISION-1:0]),
        .q_i     (IFP_dfe_in.tdata[DW-1:PRECISION]),
        .valid_i (IFP_dfe_in.tvalid),
        .last_i  (IFP_dfe_in.tlast),
        .p_o     (e3_p),
        .valid_o (e3_valid),
        .last_o  (e3_last),
        .clip_o  (e3_clip)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (meas_en) begin
                    state_d = (SYNC_TLAST != 0) ? ARM : ACCUM;
                end
            end
            ARM: begin
                if (!meas_en) begin
                    state_d = IDLE;
                end else if (e3_valid && e3_last) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (!meas_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Abort has priority: dropping meas_en kills an in-flight result.
    always_comb begin
        accum_en = (state_q == ACCUM) && meas_en;
    end

    always_comb begin
        acc_d   = acc_q;
        peak_d  = peak_q;
        clip_d  = clip_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        mv_d    = 1'b0;
        avg_d   = avg_q;
        rpeak_d = rpeak_q;
        rclip_d = rclip_q;
        // A completed window restarts from zero in the same cycle it is published.
        acc_base  = done_q ? '0 : acc_q;
        peak_base = done_q ? '0 : peak_q;
        clip_base = done_q ? '0 : clip_q;
        if (!accum_en) begin
            acc_d  = '0;
            peak_d = '0;
            clip_d = '0;
            cnt_d  = '0;
        end else begin
            if (done_q) begin
                mv_d    = 1'b1;
                avg_d   = PW'(acc_q >> LOG2_WIN);
                rpeak_d = peak_q;
                rclip_d = clip_q;
            end
            acc_d  = acc_base;
            peak_d = peak_base;
            clip_d = clip_base;
            if (e3_valid) begin
                acc_d  = acc_base + AW'(e3_p);
                peak_d = (e3_p > peak_base) ? e3_p : peak_base;
                clip_d = clip_base + {{LOG2_WIN{1'b0}}, e3_clip};
                cnt_d  = cnt_q + LOG2_WIN'(1);
                done_d = (cnt_q == '1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_q   <= '0;
            peak_q  <= '0;
            clip_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            mv_q    <= 1'b0;
            avg_q   <= '0;
            rpeak_q <= '0;
            rclip_q <= '0;
        end else if (clk_en) begin
            acc_q   <= acc_d;
            peak_q  <= peak_d;
            clip_q  <= clip_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            mv_q    <= mv_d;
            avg_q   <= avg_d;
            rpeak_q <= rpeak_d;
            rclip_q <= rclip_d;
        end
    end

    assign meas_valid = mv_q;
    assign pwr_avg    = avg_q;
    assign pwr_peak   = rpeak_q;
    assign clip_cnt   = rclip_q;

endmodule

// File: tb/tb_jb_iq_power_meter.sv
// Scoreboard bench: two meters (free-running and tlast-synchronised windows) on one stimulus bus.
module tb_jb_iq_power_meter;

    typedef struct {
        longint avg;
        longint peak;
        longint clip;
        int     term;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        clk_en = 1'b1;
    logic        meas_en0 = 1'b0;
    logic        meas_en1 = 1'b0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic [1:0]  tuser = '0;

    logic        mv0, mv1;
    logic [32:0] avg0, avg1, peak0, peak1;
    logic [2:0]  clip0, clip1;

    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast;
    logic [1:0]  m_tuser;
    logic        last_en = 1'b0;
    int          en_cycles = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] wi[4];
    logic [15:0] wq[4];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    jb_axi4_stream_if #(.DATA_W(32), .USER_W(2)) in0_if ();
    jb_axi4_stream_if #(.DATA_W(32), .USER_W(2)) in1_if ();
    jb_axi4_stream_if #(.DATA_W(32), .USER_W(2)) out0_if ();
    jb_axi4_stream_if #(.DATA_W(32), .USER_W(2)) out1_if ();

    assign in0_if.tdata   = tdata;
    assign in0_if.tvalid  = tvalid;
    assign in0_if.tlast   = tlast;
    assign in0_if.tuser   = tuser;
    assign in0_if.tkeep   = 4'hF;
    assign in1_if.tdata   = tdata;
    assign in1_if.tvalid  = tvalid;
    assign in1_if.tlast   = tlast;
    assign in1_if.tuser   = tuser;
    assign in1_if.tkeep   = 4'hF;
    assign out0_if.tready = 1'b1;
    assign out1_if.tready = 1'b1;

    jb_iq_power_meter #(
        .PRECISION (16), .USR_ID_BW (2), .LOG2_WIN (2), .SYNC_TLAST (0)
    ) u_dut0 (
        .clk         (clk),
        .resetn      (resetn),
        .clk_en      (clk_en),
        .meas_en     (meas_en0),
        .IFP_dfe_in  (in0_if),
        .IFP_dfe_out (out0_if),
        .meas_valid  (mv0),
        .pwr_avg     (avg0),
        .pwr_peak    (peak0),
        .clip_cnt    (clip0)
    );

    jb_iq_power_meter #(
        .PRECISION (16), .USR_ID_BW (2), .LOG2_WIN (2), .SYNC_TLAST (1)
    ) u_dut1 (
        .clk         (clk),
        .resetn      (resetn),
        .clk_en      (clk_en),
        .meas_en     (meas_en1),
        .IFP_dfe_in  (in1_if),
        .IFP_dfe_out (out1_if),
        .meas_valid  (mv1),
        .pwr_avg     (avg1),
        .pwr_peak    (peak1),
        .clip_cnt    (clip1)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference pass-through register and enabled-edge counter.
    always @(posedge clk) begin
        last_en <= clk_en && resetn;
        if (!resetn) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tuser  <= '0;
        end else if (clk_en) begin
            m_tdata   <= tdata;
            m_tvalid  <= tvalid;
            m_tlast   <= tlast;
            m_tuser   <= tuser;
            en_cycles <= en_cycles + 1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        check_eq("pt_tdata", longint'(out0_if.tdata), longint'(m_tdata));
        check_eq("pt_tvalid", longint'(out0_if.tvalid), longint'(m_tvalid));
        check_eq("pt_tlast", longint'(out0_if.tlast), longint'(m_tlast));
        check_eq("pt_tuser", longint'(out0_if.tuser), longint'(m_tuser));
        if (last_en && mv0) begin
            if (q0.size() == 0) begin
                check_eq("unexp_pulse0", longint'(mv0), 0);
            end else begin
                e = q0.pop_front();
                check_eq("avg0", longint'(avg0), e.avg);
                check_eq("peak0", longint'(peak0), e.peak);
                check_eq("clip0", longint'(clip0), e.clip);
                check_eq("latency0", longint'(en_cycles - e.term), 4);
            end
        end
        if (last_en && mv1) begin
            if (q1.size() == 0) begin
                check_eq("unexp_pulse1", longint'(mv1), 0);
            end else begin
                e = q1.pop_front();
                check_eq("avg1", longint'(avg1), e.avg);
                check_eq("peak1", longint'(peak1), e.peak);
                check_eq("clip1", longint'(clip1), e.clip);
                check_eq("latency1", longint'(en_cycles - e.term), 4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input int n);
        tvalid = 1'b0;
        tlast  = 1'b0;
        clk_en = 1'b1;
        repeat (n) tick();
    endtask

    task automatic beat(input logic [15:0] iv, input logic [15:0] qv, input logic last,
                        input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                tvalid = 1'b0;
                clk_en = 1'($urandom_range(0, 1));
                tick();
            end
            repeat ($urandom_range(0, 1)) begin
                tvalid = 1'b1;
                tdata  = {qv, iv};
                tlast  = last;
                clk_en = 1'b0;
                tick();
            end
        end
        tvalid = 1'b1;
        tdata  = {qv, iv};
        tlast  = last;
        tuser  = 2'($urandom);
        clk_en = 1'b1;
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    // dst: 1 = expect a result from the free-running meter, 2 = from the synced one.
    task automatic send_win(input bit gaps, input int dst);
        exp_t   e;
        longint si, sq, p;
        e.avg  = 0;
        e.peak = 0;
        e.clip = 0;
        for (int k = 0; k < 4; k++) begin
            si = longint'($signed(wi[k]));
            sq = longint'($signed(wq[k]));
            p  = si * si + sq * sq;
            e.avg += p;
            if (p > e.peak) e.peak = p;
            if (wi[k] == 16'h7FFF || wi[k] == 16'h8000 || wq[k] == 16'h7FFF ||
                wq[k] == 16'h8000) e.clip += 1;
            beat(wi[k], wq[k], 1'b0, gaps);
        end
        e.avg  = e.avg >>> 2;
        e.term = en_cycles;
        if (dst == 1) q0.push_back(e);
        if (dst == 2) q1.push_back(e);
    endtask

    task automatic fill(input logic [15:0] iv, input logic [15:0] qv);
        for (int k = 0; k < 4; k++) begin
            wi[k] = iv;
            wq[k] = qv;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random input activity.
        repeat (3) begin
            tdata  = $urandom;
            tvalid = 1'($urandom);
            tuser  = 2'($urandom);
            tick();
        end
        check_eq("rst_mv0", longint'(mv0), 0);
        check_eq("rst_avg0", longint'(avg0), 0);
        check_eq("rst_peak0", longint'(peak0), 0);
        check_eq("rst_clip0", longint'(clip0), 0);
        check_eq("rst_mv1", longint'(mv1), 0);
        check_eq("rst_tready", longint'(in0_if.tready), 1);
        check_eq("rst_out_tvalid", longint'(out0_if.tvalid), 0);
        check_eq("tkeep", longint'(out0_if.tkeep), 15);
        resetn = 1'b1;
        tvalid = 1'b0;
        tdata  = '0;
        tuser  = '0;
        tick();

        // Constant I=1000 window.
        meas_en0 = 1'b1;
        tick();
        fill(16'd1000, 16'd0);
        send_win(1'b0, 1);
        flush(8);
        check_eq("t2_pending", longint'(q0.size()), 0);

        // Full-scale clip sample.
        fill(16'd0, 16'd0);
        wi[0] = 16'h7FFF;
        wq[0] = 16'h8000;
        send_win(1'b0, 1);
        flush(8);
        check_eq("t3_pending", longint'(q0.size()), 0);

        // Same as the first window, with tvalid gaps and clk_en stalls.
        fill(16'd1000, 16'd0);
        send_win(1'b1, 1);
        flush(8);
        check_eq("t4_pending", longint'(q0.size()), 0);

        // Abort a partial window; results must hold.
        beat(16'd3000, 16'd3000, 1'b0, 1'b0);
        beat(16'd3000, 16'd3000, 1'b0, 1'b0);
        meas_en0 = 1'b0;
        flush(8);
        check_eq("t5_avg_hold", longint'(avg0), 1000000);
        check_eq("t5_peak_hold", longint'(peak0), 1000000);
        check_eq("t5_clip_hold", longint'(clip0), 0);
        meas_en0 = 1'b1;
        tick();
        fill(16'd100, 16'd100);
        send_win(1'b0, 1);
        flush(8);
        check_eq("t5_pending", longint'(q0.size()), 0);

        // tlast-synchronised window start on the second meter.
        meas_en0 = 1'b0;
        tick();
        meas_en1 = 1'b1;
        tick();
        repeat (3) beat(16'd500, 16'd0, 1'b0, 1'b0);
        beat(16'd500, 16'd0, 1'b1, 1'b0);
        fill(16'd200, 16'd0);
        send_win(1'b0, 2);
        flush(8);
        check_eq("t6_pending", longint'(q1.size()), 0);

        // Drop meas_en as the terminal beat completes: no pulse, results hold.
        repeat (4) beat(16'd50, 16'd0, 1'b0, 1'b0);
        tick();
        tick();
        meas_en1 = 1'b0;
        flush(8);
        check_eq("t6_avg_hold", longint'(avg1), 40000);
        check_eq("t6_peak_hold", longint'(peak1), 40000);
        check_eq("t0_avg_untouched", longint'(avg0), 20000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
